inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset and on LOAD->RUN entry.
REQ-002 SHALL have parameter BOOT_LOAD, default 1, meaning 1 = leave reset in LOAD and 0 = leave reset in RUN.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port load_valid, input, 1 bit: a boot-load word is present.
REQ-006 SHALL have port load_data, input, 32 bits: boot-load instruction word.
REQ-007 SHALL have port load_done, input, 1 bit: the boot-load stream ends this cycle.
REQ-008 SHALL have port load_ready, output, 1 bit: the block accepts a load word this cycle.
REQ-009 SHALL have port redirect, input, 1 bit: PC redirect request (branch/jump).
REQ-010 SHALL have port redirect_target, input, 32 bits: new byte PC.
REQ-011 SHALL have port stall, input, 1 bit: hold the fetch stage.
REQ-012 SHALL have port flush, input, 1 bit: invalidate the IF/ID register.
REQ-013 SHALL have port IM_out, input, 32 bits: instruction-memory read data (combinational, same cycle as address).
REQ-014 SHALL have port IM_address, output, 16 bits: instruction-memory word address.
REQ-015 SHALL have port IM_enable, output, 1 bit: instruction-memory enable, active-low.
REQ-016 SHALL have port IM_write, output, 1 bit: instruction-memory write strobe, active-low.
REQ-017 SHALL have port IM_in, output, 32 bits: instruction-memory write data.
REQ-018 SHALL have port if_pc, output, 32 bits: PC of the instruction held in IF/ID.
REQ-019 SHALL have port if_inst, output, 32 bits: instruction held in IF/ID.
REQ-020 SHALL have port if_valid, output, 1 bit: the IF/ID contents are valid.
REQ-021 SHALL have port fetch_run, output, 1 bit: 1 while in state RUN.

Function
REQ-022 SHALL implement two states: LOAD and RUN; the block never returns from RUN to LOAD except via reset.
REQ-023 In LOAD, SHALL drive load_ready=1, IM_address=load_ptr, IM_in=load_data, and IM_enable=IM_write=~load_valid.
REQ-024 In LOAD, a cycle with load_valid=1 SHALL write one word and increment the 16-bit load_ptr; the pointer wraps from 16'hFFFF to 0 silently.
REQ-025 In LOAD, load_done=1 SHALL move to RUN at the next edge with PC=RESET_PC; a word presented in the same cycle is still written.
REQ-026 In LOAD, redirect, stall and flush SHALL be ignored, and if_valid SHALL stay 0.
REQ-027 In RUN, SHALL drive load_ready=0, IM_enable=0, IM_write=1, IM_in=0, and IM_address=PC[17:2].
REQ-028 In RUN, edge priority SHALL be redirect > flush > stall > normal.
REQ-029 On redirect, SHALL set PC = {redirect_target[31:2],2'b00} and if_valid=0; if_pc and if_inst are unchanged.
REQ-030 On flush without redirect, SHALL set if_valid=0 and hold PC.
REQ-031 On stall without redirect or flush, SHALL hold PC, if_pc, if_inst and if_valid.
REQ-032 On a normal cycle, SHALL set if_pc=PC, if_inst=IM_out, if_valid=1 and PC=PC+4; fetch latency is 1 cycle from address to IF/ID.
REQ-033 PC arithmetic SHALL be 32-bit modulo 2^32; the IM address aliases every 256 KiB.

Reset
REQ-034 While rst_n=0 at an edge, SHALL set PC=RESET_PC, load_ptr=0, if_pc=0, if_inst=0, if_valid=0, and state=LOAD if BOOT_LOAD=1, else RUN.
REQ-035 During a reset cycle, SHALL drive IM_enable=1 and IM_write=1 so that no memory access occurs.
REQ-036 Reset asserted mid-load or mid-run SHALL abandon the operation; no partial word write completes at that edge.

Verification
REQ-037 Boot load: 3 words A,B,C with load_valid (C coincides with load_done) -> IM words 0..2 = A,B,C; fetch_run=1 on the next cycle; first if_inst=A with if_pc=0.
REQ-038 Gapped load: load_valid low for 2 cycles between words -> IM_write stays 1 on the gap cycles; load_ptr does not advance.
REQ-039 Sequential fetch: RUN with no stall -> if_pc sequence 0,4,8,12 on consecutive cycles; if_valid=1 throughout.
REQ-040 Redirect and stall together: redirect_target=32'h0000_0102 -> next cycle if_valid=0, IM_address=16'h0040; the following cycle if_pc=32'h100.
REQ-041 Stall 3 cycles -> if_pc/if_inst frozen for 3 cycles, then resume at +4.
REQ-042 Reset mid-load after 2 words, with BOOT_LOAD=1 -> load_ptr=0, if_valid=0, state=LOAD; the next load word is written at address 0.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch stage: boot-loads instruction memory in LOAD, then fetches
// sequentially into the IF/ID register in RUN with redirect/flush/stall control.
module inst_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter bit          BOOT_LOAD = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  input  logic        load_done,
  output logic        load_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] IM_out,
  output logic [15:0] IM_address,
  output logic        IM_enable,
  output logic        IM_write,
  output logic [31:0] IM_in,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid,
  output logic        fetch_run
);

  typedef enum logic {S_LOAD, S_RUN} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [15:0] ptr_q, ptr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic        if_valid_q, if_valid_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= BOOT_LOAD ? S_LOAD : S_RUN;
      pc_q       <= RESET_PC;
      ptr_q      <= '0;
      if_pc_q    <= '0;
      if_inst_q  <= '0;
      if_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ptr_q      <= ptr_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
      if_valid_q <= if_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ptr_d      = ptr_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    if_valid_d = if_valid_q;
    unique case (state_q)
      S_LOAD: begin
        if (load_valid) ptr_d = ptr_q + 16'd1;
        if (load_done) begin
          state_d = S_RUN;
          pc_d    = RESET_PC;
        end
      end
      S_RUN: begin
        if (redirect) begin
          pc_d       = redirect_target & ~32'd3;
          if_valid_d = 1'b0;
        end else if (flush) begin
          if_valid_d = 1'b0;
        end else if (!stall) begin
          if_pc_d    = pc_q;
          if_inst_d  = IM_out;
          if_valid_d = 1'b1;
          pc_d       = pc_q + 32'd4;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_comb begin
    load_ready = 1'b0;
    IM_address = pc_q[17:2];
    IM_enable  = 1'b0;
    IM_write   = 1'b1;
    IM_in      = '0;
    if (state_q == S_LOAD) begin
      load_ready = 1'b1;
      IM_address = ptr_q;
      IM_in      = load_data;
      IM_enable  = ~load_valid;
      IM_write   = ~load_valid;
    end
    // Reset overrides any access so no partial write lands on the reset edge.
    if (!rst_n) begin
      IM_enable = 1'b1;
      IM_write  = 1'b1;
    end
  end

  assign if_pc     = if_pc_q;
  assign if_inst   = if_inst_q;
  assign if_valid  = if_valid_q;
  assign fetch_run = (state_q == S_RUN);

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed boot/fetch table, hand-written
// reset corner cases, and random stimulus against a behavioural model.
module tb_inst_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] WA = 32'h1111_AAAA, WB = 32'h2222_BBBB, WC = 32'h3333_CCCC;

  logic        clk;
  logic        rst_n, load_valid, load_done, load_ready, redirect, stall, flush;
  logic [31:0] load_data, redirect_target, IM_out, IM_in, if_pc, if_inst;
  logic [15:0] IM_address;
  logic        IM_enable, IM_write, if_valid, fetch_run;

  logic        load_ready2, IM_enable2, IM_write2, if_valid2, fetch_run2;
  logic [31:0] IM_out2, IM_in2, if_pc2, if_inst2;
  logic [15:0] IM_address2;

  logic [31:0] mem     [65536];
  logic [31:0] exp_mem [65536];

  int errors = 0;
  int checks = 0;

  bit          m_run;
  int unsigned m_ptr;
  logic [31:0] m_pc, m_ifpc, m_ifinst;
  logic        m_ifv;

  typedef struct {
    logic        redirect;
    logic [31:0] tgt;
    logic        stall;
    logic        flush;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic        e_valid;
    logic [15:0] e_addr;
  } vec_t;
  vec_t tbl [14];

  inst_fetch #(.RESET_PC(RST_PC), .BOOT_LOAD(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_data(load_data),
    .load_done(load_done), .load_ready(load_ready), .redirect(redirect),
    .redirect_target(redirect_target), .stall(stall), .flush(flush),
    .IM_out(IM_out), .IM_address(IM_address), .IM_enable(IM_enable),
    .IM_write(IM_write), .IM_in(IM_in), .if_pc(if_pc), .if_inst(if_inst),
    .if_valid(if_valid), .fetch_run(fetch_run)
  );

  inst_fetch #(.RESET_PC(32'h0000_1000), .BOOT_LOAD(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .load_valid(1'b0), .load_data(32'h0),
    .load_done(1'b0), .load_ready(load_ready2), .redirect(1'b0),
    .redirect_target(32'h0), .stall(1'b0), .flush(1'b0),
    .IM_out(IM_out2), .IM_address(IM_address2), .IM_enable(IM_enable2),
    .IM_write(IM_write2), .IM_in(IM_in2), .if_pc(if_pc2), .if_inst(if_inst2),
    .if_valid(if_valid2), .fetch_run(fetch_run2)
  );

  assign IM_out  = mem[IM_address];
  assign IM_out2 = {16'hA5A5, IM_address2};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // One clock cycle: check memory-side outputs, advance model, check IF/ID.
  task automatic tick();
    logic        we;
    logic [15:0] wa;
    logic [31:0] wd;
    #1;
    if (!rst_n) begin
      chk("rst_im_enable", 32'(IM_enable), 32'd1);
      chk("rst_im_write", 32'(IM_write), 32'd1);
    end else if (!m_run) begin
      chk("load_ready", 32'(load_ready), 32'd1);
      chk("load_addr", 32'(IM_address), 32'(m_ptr[15:0]));
      chk("load_im_enable", 32'(IM_enable), 32'(!load_valid));
      chk("load_im_write", 32'(IM_write), 32'(!load_valid));
      chk("load_im_in", IM_in, load_data);
    end else begin
      chk("run_load_ready", 32'(load_ready), 32'd0);
      chk("run_addr", 32'(IM_address), 32'(m_pc[17:2]));
      chk("run_im_enable", 32'(IM_enable), 32'd0);
      chk("run_im_write", 32'(IM_write), 32'd1);
      chk("run_im_in", IM_in, 32'd0);
    end
    we = !IM_enable && !IM_write;
    wa = IM_address;
    wd = IM_in;
    if (!rst_n) begin
      m_run = 1'b0; m_ptr = 0; m_pc = RST_PC;
      m_ifpc = '0; m_ifinst = '0; m_ifv = 1'b0;
    end else if (!m_run) begin
      if (load_valid) begin
        exp_mem[m_ptr] = load_data;
        m_ptr = (m_ptr + 1) % 65536;
      end
      if (load_done) begin
        m_run = 1'b1;
        m_pc  = RST_PC;
      end
    end else if (redirect) begin
      m_pc  = (redirect_target / 4) * 4;
      m_ifv = 1'b0;
    end else if (flush) begin
      m_ifv = 1'b0;
    end else if (!stall) begin
      m_ifpc   = m_pc;
      m_ifinst = exp_mem[(m_pc / 4) % 65536];
      m_ifv    = 1'b1;
      m_pc     = m_pc + 32'd4;
    end
    @(posedge clk);
    if (we) mem[wa] = wd;
    #1;
    chk("if_pc", if_pc, m_ifpc);
    chk("if_inst", if_inst, m_ifinst);
    chk("if_valid", 32'(if_valid), 32'(m_ifv));
    chk("fetch_run", 32'(fetch_run), 32'(m_run));
    @(negedge clk);
  endtask

  task automatic drive(input logic lv, input logic [31:0] ld, input logic dn);
    load_valid = lv; load_data = ld; load_done = dn;
  endtask

  initial begin
    tbl[0]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         WA,            1'b1, 16'h0001};
    tbl[1]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h4,         WB,            1'b1, 16'h0002};
    tbl[2]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h8,         WC,            1'b1, 16'h0003};
    tbl[3]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'hC,         32'h1000_0003, 1'b1, 16'h0004};
    tbl[4]  = '{1'b1, 32'h0000_0102, 1'b1, 1'b0, 32'hC,         32'h1000_0003, 1'b0, 16'h0040};
    tbl[5]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h100,       32'h1000_0040, 1'b1, 16'h0041};
    tbl[6]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h100,       32'h1000_0040, 1'b1, 16'h0041};
    tbl[7]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h100,       32'h1000_0040, 1'b1, 16'h0041};
    tbl[8]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h100,       32'h1000_0040, 1'b1, 16'h0041};
    tbl[9]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h104,       32'h1000_0041, 1'b1, 16'h0042};
    tbl[10] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h104,       32'h1000_0041, 1'b0, 16'h0042};
    tbl[11] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h108,       32'h1000_0042, 1'b1, 16'h0043};
    tbl[12] = '{1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h108,       32'h1000_0042, 1'b0, 16'hFFFF};
    tbl[13] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'hFFFF_FFFC, 32'h1000_FFFF, 1'b1, 16'h0000};

    for (int unsigned i = 0; i < 65536; i++) begin
      mem[i]     = 32'h1000_0000 | i;
      exp_mem[i] = 32'h1000_0000 | i;
    end
    rst_n = 1'b0; redirect = 1'b0; redirect_target = '0; stall = 1'b0; flush = 1'b0;
    drive(1'b1, 32'hDEAD_BEEF, 1'b0);
    @(negedge clk);

    // Reset state (main and RUN-booting instance).
    tick(); tick();
    chk("reset_if_valid", 32'(if_valid), 32'd0);
    chk("reset_fetch_run", 32'(fetch_run), 32'd0);
    chk("d2_reset_run", 32'(fetch_run2), 32'd1);
    chk("d2_reset_addr", 32'(IM_address2), 32'h400);
    chk("d2_reset_valid", 32'(if_valid2), 32'd0);

    // Boot load A, gap x2, B, C+done.
    rst_n = 1'b1;
    drive(1'b1, WA, 1'b0); tick();
    chk("d2_first_pc", if_pc2, 32'h0000_1000);
    chk("d2_first_inst", if_inst2, 32'hA5A5_0400);
    chk("d2_first_valid", 32'(if_valid2), 32'd1);
    chk("d2_im_ctrl", {29'd0, load_ready2, IM_enable2, IM_write2}, 32'd1);
    chk("d2_im_in", IM_in2, 32'd0);
    drive(1'b0, 32'h5555_5555, 1'b0); tick();
    chk("gap_im_write", 32'(IM_write), 32'd1);
    chk("gap_ptr_hold", 32'(IM_address), 32'd1);
    tick();
    chk("gap2_im_write", 32'(IM_write), 32'd1);
    chk("gap2_ptr_hold", 32'(IM_address), 32'd1);
    drive(1'b1, WB, 1'b0); tick();
    drive(1'b1, WC, 1'b1); tick();
    chk("boot_fetch_run", 32'(fetch_run), 32'd1);
    drive(1'b0, 32'h0, 1'b0);

    for (int i = 0; i < 14; i++) begin
      redirect = tbl[i].redirect; redirect_target = tbl[i].tgt;
      stall = tbl[i].stall; flush = tbl[i].flush;
      tick();
      chk($sformatf("tbl%0d_pc", i), if_pc, tbl[i].e_pc);
      chk($sformatf("tbl%0d_inst", i), if_inst, tbl[i].e_inst);
      chk($sformatf("tbl%0d_valid", i), 32'(if_valid), 32'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_addr", i), 32'(IM_address), 32'(tbl[i].e_addr));
    end
    redirect = 1'b0; stall = 1'b0; flush = 1'b0;

    // Reset mid-load after two words; the word offered on the reset edge is dropped.
    rst_n = 1'b0; tick();
    rst_n = 1'b1;
    drive(1'b1, 32'hAAAA_0000, 1'b0); tick();
    drive(1'b1, 32'hAAAA_0001, 1'b0); tick();
    rst_n = 1'b0; drive(1'b1, 32'hBAD0_BAD0, 1'b0); tick();
    chk("midrst_valid", 32'(if_valid), 32'd0);
    chk("midrst_run", 32'(fetch_run), 32'd0);
    rst_n = 1'b1; drive(1'b1, 32'hC0DE_0000, 1'b1); tick();
    drive(1'b0, 32'h0, 1'b0); tick();
    chk("midrst_inst0", if_inst, 32'hC0DE_0000);
    chk("midrst_pc0", if_pc, 32'h0);
    tick();
    chk("midrst_inst1", if_inst, 32'hAAAA_0001);

    // Random stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      rst_n      = ($urandom_range(199) != 0);
      load_valid = ($urandom_range(2) != 0);
      load_data  = $urandom;
      load_done  = ($urandom_range(11) == 0);
      redirect   = ($urandom_range(9) == 0);
      redirect_target = ($urandom_range(3) == 0) ? $urandom : ($urandom & 32'h0000_03FF);
      stall      = ($urandom_range(4) == 0);
      flush      = ($urandom_range(7) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
